// File: rtl/regfile_wr_sched_pkg.sv
// Shared types and constants for the register-file write-port scheduler.
// wr_req_t is one queued B write: squashed entries still occupy a slot but never write.
package regfile_wr_sched_pkg;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam logic [AW-1:0] REG_PC = 4'hF;

    typedef struct packed {
        logic          valid;
        logic          squashed;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wr_req_t;

endpackage

// File: rtl/regfile_wr_fifo.sv
// DEPTH-entry FIFO of B writes with every entry exposed for parallel hazard compare.
// A squash marks matching entries (including the one being pushed) as dead in place.
module regfile_wr_fifo
    import regfile_wr_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [AW-1:0]            push_wa,
    input  logic [DW-1:0]            push_wd,
    input  logic                     pop,
    input  logic                     squash_en,
    input  logic [AW-1:0]            squash_wa,
    output wr_req_t                  head,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DEPTH-1:0]         live,
    output logic [AW-1:0]            addr [DEPTH]
);

    localparam int PW = $clog2(DEPTH);

    wr_req_t             ent [DEPTH];
    logic [PW-1:0]       rd_ptr_reg;
    logic [PW-1:0]       wr_ptr_reg;
    logic [PW:0]         count_reg;
    logic                push_squash;

    assign push_squash = squash_en && (push_wa == squash_wa);
    assign head        = ent[rd_ptr_reg];
    assign count       = count_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            wr_req_t entry_reg;

            // Push and pop never collide on a slot except when full, where the push wins.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == PW'(gi))) begin
                    entry_reg <= '{valid: 1'b1, squashed: push_squash, wa: push_wa, wd: push_wd};
                end else if (pop && (rd_ptr_reg == PW'(gi))) begin
                    entry_reg <= '0;
                end else if (squash_en && entry_reg.valid && (entry_reg.wa == squash_wa)) begin
                    entry_reg.squashed <= 1'b1;
                end
            end

            assign ent[gi]  = entry_reg;
            assign live[gi] = entry_reg.valid & ~entry_reg.squashed;
            assign addr[gi] = entry_reg.wa;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wr_sched.sv
// Arbitrates the single regfile write port between the datapath (A) and a queued
// multicycle unit (B), stalling the datapath on read hazards and B starvation.
module regfile_wr_sched
    import regfile_wr_sched_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          a_we,
    input  logic [AW-1:0] a_wa,
    input  logic [DW-1:0] a_wd,
    input  logic          b_valid,
    input  logic [AW-1:0] b_wa,
    input  logic [DW-1:0] b_wd,
    output logic          b_ready,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic [AW-1:0] ra4,
    output logic          we3,
    output logic [AW-1:0] wa3,
    output logic [DW-1:0] wd3,
    output logic          stall,
    output logic          q_empty
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT) + 1;

    wr_req_t          head;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] live;
    logic [AW-1:0]    addr [DEPTH];
    logic [WW-1:0]    wait_cnt_reg;
    logic [WW-1:0]    wait_cnt_next;
    logic             a_eff;
    logic             a_pc;
    logic             a_wins;
    logic             pop;
    logic             push;
    logic             squash_en;
    logic             hz;
    logic             starve;

    function automatic logic reads_match(input logic [AW-1:0] wa, input logic [AW-1:0] r1,
                                         input logic [AW-1:0] r2, input logic [AW-1:0] r4);
        return ((r1 != REG_PC) && (r1 == wa)) ||
               ((r2 != REG_PC) && (r2 == wa)) ||
               ((r4 != REG_PC) && (r4 == wa));
    endfunction

    // The offered B write is checked regardless of b_ready: if it hazards, stall forces a
    // pop, which makes room, so it is accepted anyway. This keeps stall free of loops.
    always_comb begin
        hz = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && reads_match(addr[i], ra1, ra2, ra4)) hz = 1'b1;
        end
        if (b_valid && (b_wa != REG_PC) && reads_match(b_wa, ra1, ra2, ra4)) hz = 1'b1;
    end

    assign starve  = (wait_cnt_reg == WW'(MAX_WAIT - 1));
    assign stall   = hz | starve;
    assign q_empty = (count == '0);

    always_comb begin
        a_eff     = a_we & ~stall;
        a_pc      = (a_wa == REG_PC);
        a_wins    = 1'b0;
        pop       = 1'b0;
        we3       = 1'b0;
        wa3       = '0;
        wd3       = '0;
        if (a_eff) begin
            a_wins = 1'b1;
            if (!a_pc) begin
                we3 = 1'b1;
                wa3 = a_wa;
                wd3 = a_wd;
            end
        end else if (head.valid) begin
            pop = 1'b1;
            if (!head.squashed) begin
                we3 = 1'b1;
                wa3 = head.wa;
                wd3 = head.wd;
            end
        end
        squash_en = a_eff & ~a_pc;
        b_ready   = (count < CW'(DEPTH)) | pop;
        push      = b_valid & b_ready & (b_wa != REG_PC);
    end

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (!head.valid || pop) begin
            wait_cnt_next = '0;
        end else if (a_wins && (wait_cnt_reg != '1)) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wait_cnt_reg <= '0;
        else          wait_cnt_reg <= wait_cnt_next;
    end

    regfile_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_wa   (b_wa),
        .push_wd   (b_wd),
        .pop       (pop),
        .squash_en (squash_en),
        .squash_wa (a_wa),
        .head      (head),
        .count     (count),
        .live      (live),
        .addr      (addr)
    );

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench: stimulus queues expected port writes and control values; a negedge
// monitor pops and compares them against the scheduler outputs.
module tb_regfile_wr_sched;
    import regfile_wr_sched_pkg::*;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          a_we;
    logic [AW-1:0] a_wa;
    logic [DW-1:0] a_wd;
    logic          b_valid;
    logic [AW-1:0] b_wa;
    logic [DW-1:0] b_wd;
    logic          b_ready;
    logic [AW-1:0] ra1, ra2, ra4;
    logic          we3;
    logic [AW-1:0] wa3;
    logic [DW-1:0] wd3;
    logic          stall;
    logic          q_empty;

    regfile_wr_sched #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_we(a_we), .a_wa(a_wa), .a_wd(a_wd),
        .b_valid(b_valid), .b_wa(b_wa), .b_wd(b_wd), .b_ready(b_ready),
        .ra1(ra1), .ra2(ra2), .ra4(ra4),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .stall(stall), .q_empty(q_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wr_t;

    typedef enum int {S_WE3, S_STALL, S_BREADY, S_QEMPTY, S_SBLEFT} sig_e;

    typedef struct {
        sig_e        id;
        logic [31:0] val;
        string       tag;
    } ctl_t;

    wr_t  wr_q[$];
    ctl_t ctl_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] sample(input sig_e id);
        case (id)
            S_WE3:    return {31'b0, we3};
            S_STALL:  return {31'b0, stall};
            S_BREADY: return {31'b0, b_ready};
            S_QEMPTY: return {31'b0, q_empty};
            default:  return 32'(wr_q.size());
        endcase
    endfunction

    wr_t         mon_e;
    ctl_t        mon_c;
    logic [31:0] mon_act;

    always @(negedge clk) begin
        if (reset_n && we3) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got wa=%0d wd=%h want no write", wa3, wd3);
            end else begin
                mon_e = wr_q.pop_front();
                if (wa3 !== mon_e.wa || wd3 !== mon_e.wd) begin
                    errors++;
                    $display("FAIL write got wa=%0d wd=%h want wa=%0d wd=%h",
                             wa3, wd3, mon_e.wa, mon_e.wd);
                end else begin
                    $display("write wa=%0d wd=%h ok", wa3, wd3);
                end
            end
        end
        while (ctl_q.size() > 0) begin
            mon_c   = ctl_q.pop_front();
            mon_act = sample(mon_c.id);
            checks++;
            if (mon_act !== mon_c.val) begin
                errors++;
                $display("FAIL %s got %0h want %0h", mon_c.tag, mon_act, mon_c.val);
            end else begin
                $display("check %s = %0h ok", mon_c.tag, mon_act);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        a_we = we; a_wa = wa; a_wd = wd;
    endtask

    task automatic set_b(input logic v, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        b_valid = v; b_wa = wa; b_wd = wd;
    endtask

    task automatic exp_wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        wr_q.push_back('{wa: wa, wd: wd});
    endtask

    task automatic exp(input sig_e id, input logic [31:0] val, input string tag);
        ctl_q.push_back('{id: id, val: val, tag: tag});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        set_a(0, 0, 0);
        set_b(1, 4'd2, 32'h55);
        ra1 = 0; ra2 = 0; ra4 = 0;
        repeat (2) @(posedge clk);
        #1;
        exp(S_BREADY, 1, "rst_bready");
        exp(S_WE3, 0, "rst_we3");
        exp(S_STALL, 0, "rst_stall");
        exp(S_QEMPTY, 1, "rst_qempty");
        tick(); reset_n = 1'b1; set_b(0, 0, 0);
        exp(S_QEMPTY, 1, "rst_b_not_queued");
        exp(S_WE3, 0, "rst_release_we3");

        // A-only writes, including the PC address which must not reach the port
        tick(); set_a(1, 4'd3, 32'hDEADBEEF); exp_wr(4'd3, 32'hDEADBEEF); exp(S_WE3, 1, "a_we3");
        tick(); set_a(1, 4'd15, 32'h1234); exp(S_WE3, 0, "a_pc_we3");
        tick(); set_a(0, 0, 0);

        // B writes queued behind A, then drained in order
        tick(); set_a(1, 4'd1, 32'h101); set_b(1, 4'd4, 32'h11); exp_wr(4'd1, 32'h101);
        exp(S_BREADY, 1, "drain_bready");
        tick(); set_a(1, 4'd2, 32'h202); set_b(1, 4'd5, 32'h22); exp_wr(4'd2, 32'h202);
        tick(); set_a(0, 0, 0); set_b(0, 0, 0); exp_wr(4'd4, 32'h11);
        tick(); exp_wr(4'd5, 32'h22); exp(S_QEMPTY, 0, "drain_not_empty");
        tick(); exp(S_QEMPTY, 1, "drain_empty"); exp(S_WE3, 0, "drain_idle_we3");

        // B write to the PC address is accepted and discarded
        tick(); set_b(1, 4'd15, 32'hEE); exp(S_BREADY, 1, "pc_b_ready");
        tick(); set_b(0, 0, 0); exp(S_QEMPTY, 1, "pc_b_discard"); exp(S_WE3, 0, "pc_b_we3");

        // Fill the queue while A holds the port, then starvation forces a drain
        for (int t = 0; t < 4; t++) begin
            tick(); set_a(1, 4'd1, 32'hA0 + t); set_b(1, 4'(8 + t), 32'h80 + t);
            exp_wr(4'd1, 32'hA0 + t);
        end
        tick(); set_a(1, 4'd1, 32'hA4); set_b(1, 4'd12, 32'hC0);
        exp(S_BREADY, 0, "full_bready"); exp_wr(4'd1, 32'hA4);
        for (int t = 5; t < 8; t++) begin
            tick(); set_a(1, 4'd1, 32'hA0 + t); set_b(0, 0, 0);
            exp(S_STALL, 0, "starve_not_yet"); exp_wr(4'd1, 32'hA0 + t);
        end
        tick(); set_a(1, 4'd1, 32'hA8); set_b(1, 4'd13, 32'hD0);
        exp(S_STALL, 1, "starve_stall"); exp(S_BREADY, 1, "full_push_pop"); exp_wr(4'd8, 32'h80);
        tick(); set_a(1, 4'd1, 32'hA9); set_b(0, 0, 0);
        exp(S_STALL, 0, "starve_release"); exp_wr(4'd1, 32'hA9);
        tick(); set_a(0, 0, 0); exp_wr(4'd9, 32'h81);
        tick(); exp_wr(4'd10, 32'h82);
        tick(); exp_wr(4'd11, 32'h83);
        tick(); exp_wr(4'd13, 32'hD0);
        tick(); exp(S_QEMPTY, 1, "full_empty");

        // Read hazard on a queued address holds stall until that entry drains
        tick(); set_a(1, 4'd1, 32'h31); set_b(1, 4'd12, 32'hC1); exp_wr(4'd1, 32'h31);
        tick(); set_a(1, 4'd1, 32'h32); set_b(1, 4'd7, 32'h77); exp_wr(4'd1, 32'h32);
        tick(); set_a(1, 4'd1, 32'h33); set_b(0, 0, 0); ra2 = 4'd7;
        exp(S_STALL, 1, "hz_stall_first"); exp_wr(4'd12, 32'hC1);
        tick(); set_a(1, 4'd1, 32'h34); exp(S_STALL, 1, "hz_stall_second"); exp_wr(4'd7, 32'h77);
        tick(); set_a(1, 4'd1, 32'h35); exp(S_STALL, 0, "hz_clear"); exp_wr(4'd1, 32'h35);
        tick(); set_a(0, 0, 0); ra2 = 4'd0; exp(S_QEMPTY, 1, "hz_empty");

        // WAW squash of a queued entry by a later A write
        tick(); set_a(1, 4'd1, 32'h41); set_b(1, 4'd6, 32'hAA); exp_wr(4'd1, 32'h41);
        tick(); set_a(1, 4'd6, 32'hBB); set_b(0, 0, 0); exp_wr(4'd6, 32'hBB);
        tick(); set_a(0, 0, 0);
        exp(S_WE3, 0, "squash_pop_we3"); exp(S_QEMPTY, 0, "squash_pop_qempty");
        tick(); exp(S_QEMPTY, 1, "squash_empty");

        // Incoming B entry squashed by an A write in the same cycle
        tick(); set_a(1, 4'd6, 32'hCC); set_b(1, 4'd6, 32'hDD); exp_wr(4'd6, 32'hCC);
        exp(S_BREADY, 1, "push_squash_bready");
        tick(); set_a(0, 0, 0); set_b(0, 0, 0);
        exp(S_WE3, 0, "push_squash_we3"); exp(S_QEMPTY, 0, "push_squash_qempty");
        tick(); exp(S_QEMPTY, 1, "push_squash_empty"); exp(S_SBLEFT, 0, "scoreboard_drained");

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
